hub75_bcm_driver: RTL

- Parametrised HUB75 LED-matrix scan driver for panels of COLS x ROWS with 1/(ROWS/2) scan.
- Drives two half-panels in parallel (R0/G0/B0 top, R1/G1/B1 bottom).
- Reads pixel colour from an external synchronous framebuffer and produces BITS-deep colour with binary-code modulation (BCM).
- Sits between the framebuffer RAM and the panel connector; the CPU only writes the framebuffer.

---
 rtl/hub75_bcm_driver_if.sv | 10 +
 rtl/hub75_bcm_driver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver_if.sv
// hub75_bcm_driver_if: framebuffer read port between the scan driver and the pixel RAM
interface hub75_bcm_driver_if #(
    parameter int AW = 9,
    parameter int DW = 18
);
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_rdata;
    modport master (output fb_addr, input fb_rdata);
    modport slave (input fb_addr, output fb_rdata);
endinterface

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 panel scan driver with binary-code modulation; `define HUB75_BRIGHTNESS_EN adds a brightness input
module hub75_bcm_driver #(
    parameter int COLS = 32,
    parameter int ROWS = 32,
    parameter int BITS = 3,
    parameter int CLK_DIV = 5,
    parameter int BASE_WAIT = 64,
    localparam int SR = ROWS / 2,
    localparam int RW = $clog2(SR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    hub75_bcm_driver_if.master fb,
    output logic          clk_screen,
    output logic          R0,
    output logic          G0,
    output logic          B0,
    output logic          R1,
    output logic          G1,
    output logic          B1,
    output logic          blank,
    output logic          latch,
    output logic [RW-1:0] row,
    output logic          frame_done
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BPW = BITS > 1 ? $clog2(BITS) : 1;
    localparam int SMAX = BASE_WAIT << (BITS - 1);
    localparam int NW = $clog2((SMAX > CLK_DIV ? SMAX : CLK_DIV) + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, NEXT} state_t;

    state_t           state_q;
    logic [PW-1:0]    p_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [BPW-1:0]   plane_q;
    logic [NW-1:0]    cnt_q;
    logic [NW-1:0]    lim_q;
    logic [RW+CW-1:0] fb_addr_q;
    logic [5:0]       rgb_q;
    logic [NW-1:0]    len_d;
    logic [NW-1:0]    lim_d;
    logic [6*BITS-1:0] sh_d;
    logic [5:0]       bits_d;

    assign fb.fb_addr = fb_addr_q;
    assign {R0, G0, B0, R1, G1, B1} = rgb_q;

    // Plane display length, its lit portion, and the current plane bit of every colour field
    always_comb begin
        len_d = NW'(BASE_WAIT << plane_q);
`ifdef HUB75_BRIGHTNESS_EN
        lim_d = NW'(({8'd0, len_d} * {{NW{1'b0}}, brightness}) >> 8);
`else
        lim_d = len_d;
`endif
        sh_d = fb.fb_rdata >> plane_q;
        bits_d = {sh_d[5*BITS], sh_d[4*BITS], sh_d[3*BITS], sh_d[2*BITS], sh_d[BITS], sh_d[0]};
    end

    // Scan sequencer: shift a row, latch it, light it for the plane weight, then advance plane and row
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            p_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            cnt_q      <= '0;
            lim_q      <= '0;
            fb_addr_q  <= '0;
            rgb_q      <= '0;
            clk_screen <= 1'b0;
            blank      <= 1'b1;
            latch      <= 1'b0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= SHIFT;
                        p_q     <= '0;
                        col_q   <= '0;
                        plane_q <= '0;
                    end
                end
                SHIFT: begin
                    p_q <= p_q + 1'b1;
                    if (p_q == PW'(1)) rgb_q <= bits_d;
                    if (p_q == PW'(CLK_DIV)) clk_screen <= 1'b1;
                    if (p_q == PW'(2 * CLK_DIV - 1)) begin
                        clk_screen <= 1'b0;
                        p_q        <= '0;
                        col_q      <= col_q + 1'b1;
                        fb_addr_q  <= {row_q, col_q + 1'b1};
                        if (col_q == CW'(COLS - 1)) begin
                            state_q <= LATCH;
                            latch   <= 1'b1;
                            row     <= row_q;
                            cnt_q   <= '0;
                        end
                    end
                end
                LATCH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == NW'(CLK_DIV - 1)) begin
                        latch   <= 1'b0;
                        state_q <= SHOW;
                        cnt_q   <= '0;
                        lim_q   <= lim_d;
                        blank   <= (lim_d == '0);
                    end
                end
                SHOW: begin
                    cnt_q <= cnt_q + 1'b1;
                    blank <= !(cnt_q + 1'b1 < lim_q);
                    if (cnt_q == len_d - 1'b1) begin
                        blank   <= 1'b1;
                        state_q <= NEXT;
                        cnt_q   <= '0;
                    end
                end
                NEXT: begin
                    state_q <= SHIFT;
                    p_q     <= '0;
                    col_q   <= '0;
                    if (plane_q != BPW'(BITS - 1)) plane_q <= plane_q + 1'b1;
                    else begin
                        plane_q <= '0;
                        if (row_q != RW'(SR - 1)) begin
                            row_q     <= row_q + 1'b1;
                            fb_addr_q <= {row_q + 1'b1, CW'(0)};
                        end else begin
                            row_q      <= '0;
                            fb_addr_q  <= '0;
                            frame_done <= 1'b1;
                            if (!enable) state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
